mc_controller: RTL
==================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 clk  in  1  single clock; every state register updates on its rising edge.
REQ-003 reset_n  in  1  active-low reset, asynchronous assert, released synchronously to clk by the integrator.
REQ-004 op  in  7  opcode field instr[6:0] from the instruction register.
REQ-005 funct3  in  3  instr[14:12].
REQ-006 funct7b5  in  1  instr[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access completes this cycle.
REQ-009 pcwrite, irwrite, memwrite, regwrite, adrsrc  out  1 each  datapath strobes/selects.
REQ-010 alusrca, alusrcb, resultsrc  out  2 each  mux selects.
REQ-011 immsrc  out  3  extender select: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-012 alucontrol  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-013 instr_done  out  1  one-cycle pulse per retired instruction.
REQ-014 illegal  out  1  one-cycle pulse on unsupported opcode.

Function
REQ-015 Supported opcodes SHALL be lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111, lui 0110111.
REQ-016 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI.
REQ-017 immsrc SHALL decode combinationally from op in every state: lw/I-ALU 000, sw 001, beq 010, jal 011, lui 100, others 000.
REQ-018 FETCH: adrsrc 0, alusrca 00, alusrcb 10, add, resultsrc 10; irwrite=pcupdate=mem_ready; stays until mem_ready, then DECODE.
REQ-019 DECODE: alusrca 01, alusrcb 01, add; next lw/sw MEMADR, R EXECR, I-ALU EXECI, beq BEQ, jal JAL, lui LUI, otherwise FETCH with illegal=1.
REQ-020 MEMADR: alusrca 10, alusrcb 01, add; next MEMREAD for lw, MEMWRITE for sw.
REQ-021 MEMREAD: adrsrc 1, resultsrc 00; holds until mem_ready, then MEMWB.
REQ-022 MEMWB: resultsrc 01, regwrite 1, instr_done 1; next FETCH.
REQ-023 MEMWRITE: adrsrc 1, resultsrc 00, memwrite 1 held until mem_ready; on mem_ready instr_done 1, next FETCH.
REQ-024 EXECR: alusrca 10, alusrcb 00, aluop 10; EXECI: alusrca 10, alusrcb 01, aluop 10; both next ALUWB.
REQ-025 ALUWB: resultsrc 00, regwrite 1, instr_done 1; next FETCH.
REQ-026 BEQ: alusrca 10, alusrcb 00, sub, resultsrc 00, branch 1, instr_done 1; next FETCH.
REQ-027 JAL: alusrca 01, alusrcb 10, add, resultsrc 00, pcupdate 1; next ALUWB.
REQ-028 LUI: alusrca 11 (zero), alusrcb 01, add; next ALUWB.
REQ-029 pcwrite SHALL equal pcupdate OR (branch AND zero); all other outputs SHALL be Moore functions of state (plus op/funct, mem_ready where stated).
REQ-030 ALU decode: aluop 00 add, 01 sub; aluop 10 by funct3: 000 sub if op[5]&funct7b5 else add, 010 slt, 110 or, 111 and, other 000.
REQ-031 Unlisted select outputs in any state SHALL be 00/0, never X.
REQ-032 mem_ready low in FETCH/MEMREAD/MEMWRITE SHALL stall indefinitely with outputs stable and no strobe except memwrite.

Reset
REQ-033 reset_n low SHALL force state FETCH asynchronously and hold pcwrite, irwrite, memwrite, regwrite, instr_done, illegal at 0 for its duration.
REQ-034 Reset asserted mid-instruction SHALL abandon it without any further write strobe; first cycle after release is FETCH.

Verification
REQ-035 Reset then mem_ready=1, op=0110011, funct3=000, funct7b5=1 -> FETCH, DECODE, EXECR (alucontrol 001), ALUWB regwrite, instr_done; 4 cycles.
REQ-036 lw with mem_ready low 3 cycles in MEMREAD -> 5 states + 3 stall cycles, regwrite only in MEMWB.
REQ-037 beq with zero=1 then zero=0 -> pcwrite 1 in BEQ only for first; immsrc 010 throughout.
REQ-038 op=1111111 -> illegal pulse in DECODE, back to FETCH, no regwrite/memwrite.
REQ-039 reset_n dropped during MEMWRITE with mem_ready=0 -> memwrite 0 immediately, FETCH after release.
REQ-040 lui and jal -> immsrc 100 / 011, alusrca 11 / 01, both end in ALUWB with regwrite.

Source files
------------

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - instruction/status fields in, datapath strobes and selects out
//
// Ports (master = controller side):
//   op, funct3, funct7b5   instruction fields from the instruction register
//   zero, mem_ready        ALU zero flag, memory access completes this cycle
//   pcwrite, irwrite, memwrite, regwrite, adrsrc   datapath strobes/selects
//   alusrca, alusrcb, resultsrc                    2-bit mux selects
//   immsrc, alucontrol                             3-bit extender / ALU selects
//   instr_done, illegal                            one-cycle event pulses
interface mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       pcwrite;
   logic       irwrite;
   logic       memwrite;
   logic       regwrite;
   logic       adrsrc;
   logic [1:0] alusrca;
   logic [1:0] alusrcb;
   logic [1:0] resultsrc;
   logic [2:0] immsrc;
   logic [2:0] alucontrol;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  op, funct3, funct7b5, zero, mem_ready,
      output pcwrite, irwrite, memwrite, regwrite, adrsrc,
             alusrca, alusrcb, resultsrc, immsrc, alucontrol,
             instr_done, illegal
   );

   modport slave (
      output op, funct3, funct7b5, zero, mem_ready,
      input  pcwrite, irwrite, memwrite, regwrite, adrsrc,
             alusrca, alusrcb, resultsrc, immsrc, alucontrol,
             instr_done, illegal
   );
endinterface

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle RV32 subset control FSM
//
// Ports:
//   clk      rising-edge clock
//   reset_n  active-low reset, asynchronous assert
//   bus      mc_controller_if.master: instruction fields and flags in,
//            datapath strobes, mux selects and event pulses out
module mc_controller (
   input  logic           clk,
   input  logic           reset_n,
   mc_controller_if.master bus
);

   localparam logic [6:0] op_lw  = 7'b0000011;
   localparam logic [6:0] op_sw  = 7'b0100011;
   localparam logic [6:0] op_r   = 7'b0110011;
   localparam logic [6:0] op_i   = 7'b0010011;
   localparam logic [6:0] op_beq = 7'b1100011;
   localparam logic [6:0] op_jal = 7'b1101111;
   localparam logic [6:0] op_lui = 7'b0110111;

   typedef enum logic [3:0] {
      st_fetch, st_decode, st_memadr, st_memread, st_memwb, st_memwrite,
      st_execr, st_execi, st_aluwb, st_beq, st_jal, st_lui
   } state_t;

   state_t     state;
   logic       pcupdate, branch;
   logic [1:0] aluop;
   logic       irwrite_c, memwrite_c, regwrite_c, done_c, illegal_c;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= st_fetch;
      end else begin
         case (state)
            st_fetch:    if (bus.mem_ready) state <= st_decode;
            st_decode: begin
               case (bus.op)
                  op_lw, op_sw: state <= st_memadr;
                  op_r:         state <= st_execr;
                  op_i:         state <= st_execi;
                  op_beq:       state <= st_beq;
                  op_jal:       state <= st_jal;
                  op_lui:       state <= st_lui;
                  default:      state <= st_fetch;
               endcase
            end
            st_memadr:   state <= (bus.op == op_sw) ? st_memwrite : st_memread;
            st_memread:  if (bus.mem_ready) state <= st_memwb;
            st_memwb:    state <= st_fetch;
            st_memwrite: if (bus.mem_ready) state <= st_fetch;
            st_execr,
            st_execi,
            st_jal,
            st_lui:      state <= st_aluwb;
            st_aluwb,
            st_beq:      state <= st_fetch;
            default:     state <= st_fetch;
         endcase
      end
   end

   // Moore decode of the state; mem_ready only qualifies the stall points.
   always_comb begin
      pcupdate      = 1'b0;
      branch        = 1'b0;
      aluop         = 2'b00;
      irwrite_c     = 1'b0;
      memwrite_c    = 1'b0;
      regwrite_c    = 1'b0;
      done_c        = 1'b0;
      illegal_c     = 1'b0;
      bus.adrsrc    = 1'b0;
      bus.alusrca   = 2'b00;
      bus.alusrcb   = 2'b00;
      bus.resultsrc = 2'b00;
      case (state)
         st_fetch: begin
            bus.alusrcb   = 2'b10;
            bus.resultsrc = 2'b10;
            irwrite_c     = bus.mem_ready;
            pcupdate      = bus.mem_ready;
         end
         st_decode: begin
            bus.alusrca = 2'b01;
            bus.alusrcb = 2'b01;
            case (bus.op)
               op_lw, op_sw, op_r, op_i, op_beq, op_jal, op_lui: illegal_c = 1'b0;
               default: illegal_c = 1'b1;
            endcase
         end
         st_memadr: begin
            bus.alusrca = 2'b10;
            bus.alusrcb = 2'b01;
         end
         st_memread:  bus.adrsrc = 1'b1;
         st_memwb: begin
            bus.resultsrc = 2'b01;
            regwrite_c    = 1'b1;
            done_c        = 1'b1;
         end
         st_memwrite: begin
            bus.adrsrc = 1'b1;
            memwrite_c = 1'b1;
            done_c     = bus.mem_ready;
         end
         st_execr: begin
            bus.alusrca = 2'b10;
            aluop       = 2'b10;
         end
         st_execi: begin
            bus.alusrca = 2'b10;
            bus.alusrcb = 2'b01;
            aluop       = 2'b10;
         end
         st_aluwb: begin
            regwrite_c = 1'b1;
            done_c     = 1'b1;
         end
         st_beq: begin
            bus.alusrca = 2'b10;
            aluop       = 2'b01;
            branch      = 1'b1;
            done_c      = 1'b1;
         end
         st_jal: begin
            bus.alusrca = 2'b01;
            bus.alusrcb = 2'b10;
            pcupdate    = 1'b1;
         end
         st_lui: begin
            bus.alusrca = 2'b11;
            bus.alusrcb = 2'b01;
         end
         default: ;
      endcase
   end

   always_comb begin
      case (bus.op)
         op_sw:   bus.immsrc = 3'b001;
         op_beq:  bus.immsrc = 3'b010;
         op_jal:  bus.immsrc = 3'b011;
         op_lui:  bus.immsrc = 3'b100;
         default: bus.immsrc = 3'b000;
      endcase
   end

   // Only R-type (op[5]=1) with funct7b5 subtracts; addi ignores instr[30].
   always_comb begin
      case (aluop)
         2'b01:   bus.alucontrol = 3'b001;
         2'b10: begin
            case (bus.funct3)
               3'b000:  bus.alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
               3'b010:  bus.alucontrol = 3'b101;
               3'b110:  bus.alucontrol = 3'b011;
               3'b111:  bus.alucontrol = 3'b010;
               default: bus.alucontrol = 3'b000;
            endcase
         end
         default: bus.alucontrol = 3'b000;
      endcase
   end

   // Strobes are gated by reset_n so that nothing writes while reset is held,
   // even though FETCH would otherwise follow mem_ready.
   assign bus.pcwrite    = reset_n & (pcupdate | (branch & bus.zero));
   assign bus.irwrite    = reset_n & irwrite_c;
   assign bus.memwrite   = reset_n & memwrite_c;
   assign bus.regwrite   = reset_n & regwrite_c;
   assign bus.instr_done = reset_n & done_c;
   assign bus.illegal    = reset_n & illegal_c;

endmodule
